// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch controller.
package if_pkg;

   // Fetch controller states: drive request, wait response, hold buffered
   // response during stall, drop a stale response after redirect.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/if_next_pc_sel.sv
// Next-PC select: redirect target or sequential pc+4 (modulo 2^32).
// With IF_MISALIGN_CHECK_EN the redirect target is forced word-aligned
// and a misaligned flag is produced for the controller.
module if_next_pc_sel
   import if_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
`ifdef IF_MISALIGN_CHECK_EN
   output logic        misaligned,
`endif
   output logic [31:0] next_pc
);

   logic [31:0] target;

`ifdef IF_MISALIGN_CHECK_EN
   assign target     = {redirect_pc[31:2], 2'b00};
   assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);
`else
   assign target     = redirect_pc;
`endif

   // Redirect wins over sequential advance; the adder wraps naturally.
   always_comb begin
      next_pc = pc + PC_STEP;
      if (redirect) next_pc = target;
   end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, one-entry
// response buffer while stalled, stale-response drop after redirect.
// Optional macro IF_MISALIGN_CHECK_EN adds the misalign pulse output and
// word-aligns redirect targets.
module if_fetch_ctrl
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
`ifdef IF_MISALIGN_CHECK_EN
   ,
   output logic        misalign
`endif
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;
   logic [31:0]  buf_instr;
   logic         accept;
   logic         busy;

`ifdef IF_MISALIGN_CHECK_EN
   logic misaligned;
`endif

   if_next_pc_sel u_next_pc_sel (
      .pc          (pc),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
`ifdef IF_MISALIGN_CHECK_EN
      .misaligned  (misaligned),
`endif
      .next_pc     (next_pc)
   );

   assign imem_req  = (state == S_REQ);
   assign imem_addr = pc;
   assign accept    = imem_req && imem_ready;
   // A request is still in flight after this edge unless its response lands now.
   assign busy      = ((state == S_WAIT || state == S_DROP) && !imem_rvalid) || accept;

   // Fetch FSM, PC and IF/ID register; redirect overrides everything incl. stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         buf_instr <= INSTR_NOP;
         if_valid  <= 1'b0;
         if_pc     <= 32'h0;
         if_instr  <= 32'h0;
      end else if (redirect) begin
         pc        <= next_pc;
         if_valid  <= 1'b0;
         buf_instr <= INSTR_NOP;
         state     <= busy ? S_DROP : S_REQ;
      end else begin
         case (state)
            S_REQ: begin
               if (accept) state <= S_WAIT;
               if (!stall) if_valid <= 1'b0;
            end
            S_WAIT: begin
               if (imem_rvalid && stall) begin
                  buf_instr <= imem_rdata;
                  state     <= S_HOLD;
               end else if (imem_rvalid) begin
                  if_valid <= 1'b1;
                  if_pc    <= pc;
                  if_instr <= imem_rdata;
                  pc       <= next_pc;
                  state    <= S_REQ;
               end else if (!stall) begin
                  if_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if_valid  <= 1'b1;
                  if_pc     <= pc;
                  if_instr  <= buf_instr;
                  buf_instr <= INSTR_NOP;
                  pc        <= next_pc;
                  state     <= S_REQ;
               end
            end
            S_DROP: begin
               if (imem_rvalid) state <= S_REQ;
               if (!stall) if_valid <= 1'b0;
            end
            default: state <= S_REQ;
         endcase
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   // One-cycle registered pulse for each misaligned redirect target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else        misalign <= misaligned;
   end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed vector table, hand
// sequences for wrap/reset/misalign, then randomized traffic against a
// transaction-level reference model and a simple memory model.
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef IF_MISALIGN_CHECK_EN
   logic        misalign;
`endif

   int checks = 0;
   int errors = 0;

   if_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .if_instr    (if_instr)
`ifdef IF_MISALIGN_CHECK_EN
      ,
      .misalign    (misalign)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      stall = s; redirect = r; redirect_pc = rp;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
   endtask

   // Reset with all inputs idle; outputs checked while reset is held.
   task automatic do_reset();
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst imem_req", {31'h0, imem_req}, 32'h1);
      chk("rst imem_addr", imem_addr, 32'h0);
      chk("rst if_valid", {31'h0, if_valid}, 32'h0);
      chk("rst if_pc", if_pc, 32'h0);
      chk("rst if_instr", if_instr, 32'h0);
`ifdef IF_MISALIGN_CHECK_EN
      chk("rst misalign", {31'h0, misalign}, 32'h0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   localparam logic [31:0] I0   = 32'h1111_0013;
   localparam logic [31:0] I4   = 32'h2222_0013;
   localparam logic [31:0] I8   = 32'h3333_0013;
   localparam logic [31:0] ISTL = 32'hDEAD_BEEF;
   localparam logic [31:0] I100 = 32'h4444_0013;
   localparam logic [31:0] I104 = 32'h5555_0013;

   vec_t tbl[17];

   // ---------------- reference + memory model ----------------
   logic [31:0] m_pc, m_if_pc, m_if_instr, m_buf, mem_addr;
   bit          m_pending, m_stale, m_held, m_valid, m_mis, mem_busy;
   int          mem_lat;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], 16'h0013} ^ 32'h00A5_0000;
   endfunction

   function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IF_MISALIGN_CHECK_EN
      return {a[31:2], 2'b00};
`else
      return a;
`endif
   endfunction

   task automatic model_init();
      m_pc = 32'h0; m_if_pc = 32'h0; m_if_instr = 32'h0; m_buf = 32'h0;
      m_pending = 0; m_stale = 0; m_held = 0; m_valid = 0; m_mis = 0;
      mem_busy = 0; mem_lat = 0; mem_addr = 32'h0;
   endtask

   task automatic step_rand();
      logic        s, r, rdy, rv, m_req, accept;
      logic [31:0] rp, rd;
      m_req = !m_pending && !m_held;
      chk("rnd imem_req", {31'h0, imem_req}, {31'h0, m_req});
      chk("rnd imem_addr", imem_addr, m_pc);
      chk("rnd if_valid", {31'h0, if_valid}, {31'h0, m_valid});
      if (m_valid) begin
         chk("rnd if_pc", if_pc, m_if_pc);
         chk("rnd if_instr", if_instr, m_if_instr);
      end
`ifdef IF_MISALIGN_CHECK_EN
      chk("rnd misalign", {31'h0, misalign}, {31'h0, m_mis});
`endif
      s   = ($urandom % 4) == 0;
      r   = ($urandom % 16) == 0;
      rp  = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      rdy = ($urandom % 10) < 7;
      rd  = $urandom;
      rv  = 1'b0;
      if (mem_busy && mem_lat == 0) begin
         rv = 1'b1;
         rd = instr_of(mem_addr);
      end else if (!mem_busy && ($urandom % 10) == 0) begin
         rv = 1'b1;  // unsolicited response, must be ignored
      end
      drive(s, r, rp, rdy, rv, rd);
      accept = m_req && rdy;

      // next-state of the architectural view
`ifdef IF_MISALIGN_CHECK_EN
      m_mis = r && (rp[1:0] != 2'b00);
`endif
      if (r) begin
         m_pending = (m_pending && !rv) || accept;
         m_stale   = m_pending;
         m_held    = 0;
         m_pc      = tgt(rp);
         m_valid   = 0;
      end else if (m_pending && m_stale) begin
         if (rv) begin m_pending = 0; m_stale = 0; end
         if (!s) m_valid = 0;
      end else if (m_pending) begin
         if (rv) begin
            m_pending = 0;
            if (s) begin
               m_held = 1; m_buf = rd;
            end else begin
               m_valid = 1; m_if_pc = m_pc; m_if_instr = rd; m_pc = m_pc + 32'd4;
            end
         end else if (!s) m_valid = 0;
      end else if (m_held) begin
         if (!s) begin
            m_held = 0; m_valid = 1; m_if_pc = m_pc; m_if_instr = m_buf; m_pc = m_pc + 32'd4;
         end
      end else begin
         if (accept) begin m_pending = 1; m_stale = 0; end
         if (!s) m_valid = 0;
      end

      // memory side: complete current response, then capture a new request
      if (mem_busy && rv) mem_busy = 0;
      else if (mem_busy) mem_lat--;
      if (imem_req && imem_ready) begin
         mem_busy = 1; mem_addr = imem_addr; mem_lat = $urandom % 3;
      end
      tick();
   endtask

   initial begin
      //            stall redir rpc      rdy rv rdata  e_req e_addr   e_val e_pc     e_instr
      tbl[0]  = '{0, 0, 32'h0,   1, 0, 32'h0, 1, 32'h000, 0, 32'h000, 32'h0};
      tbl[1]  = '{0, 0, 32'h0,   0, 1, I0,    0, 32'h000, 0, 32'h000, 32'h0};
      tbl[2]  = '{0, 0, 32'h0,   1, 0, 32'h0, 1, 32'h004, 1, 32'h000, I0};
      tbl[3]  = '{0, 0, 32'h0,   0, 1, I4,    0, 32'h004, 0, 32'h000, I0};
      tbl[4]  = '{1, 0, 32'h0,   1, 0, 32'h0, 1, 32'h008, 1, 32'h004, I4};
      tbl[5]  = '{1, 0, 32'h0,   0, 1, I8,    0, 32'h008, 1, 32'h004, I4};
      tbl[6]  = '{1, 0, 32'h0,   1, 0, 32'h0, 0, 32'h008, 1, 32'h004, I4};
      tbl[7]  = '{0, 0, 32'h0,   1, 0, 32'h0, 0, 32'h008, 1, 32'h004, I4};
      tbl[8]  = '{0, 0, 32'h0,   1, 0, 32'h0, 1, 32'h00C, 1, 32'h008, I8};
      tbl[9]  = '{0, 1, 32'h100, 0, 0, 32'h0, 0, 32'h00C, 0, 32'h008, I8};
      tbl[10] = '{0, 0, 32'h0,   0, 1, ISTL,  0, 32'h100, 0, 32'h008, I8};
      tbl[11] = '{0, 0, 32'h0,   1, 0, 32'h0, 1, 32'h100, 0, 32'h008, I8};
      tbl[12] = '{0, 0, 32'h0,   0, 1, I100,  0, 32'h100, 0, 32'h008, I8};
      tbl[13] = '{0, 0, 32'h0,   0, 0, 32'h0, 1, 32'h104, 1, 32'h100, I100};
      tbl[14] = '{0, 0, 32'h0,   1, 0, 32'h0, 1, 32'h104, 0, 32'h100, I100};
      tbl[15] = '{1, 1, 32'h200, 0, 1, I104,  0, 32'h104, 0, 32'h100, I100};
      tbl[16] = '{0, 0, 32'h0,   0, 0, 32'h0, 1, 32'h200, 0, 32'h100, I100};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("tbl[%0d] imem_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
         chk($sformatf("tbl[%0d] imem_addr", i), imem_addr, tbl[i].e_addr);
         chk($sformatf("tbl[%0d] if_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
         chk($sformatf("tbl[%0d] if_pc", i), if_pc, tbl[i].e_pc);
         chk($sformatf("tbl[%0d] if_instr", i), if_instr, tbl[i].e_instr);
         drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].ready, tbl[i].rvalid, tbl[i].rdata);
         tick();
      end

      // PC wrap at the top of the address space, then reset while WAIT.
      do_reset();
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
      tick();
      chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      tick();
      chk("wrap wait req", {31'h0, imem_req}, 32'h0);
      drive(0, 0, 32'h0, 0, 1, I0);
      tick();
      chk("wrap next addr", imem_addr, 32'h0);
      chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap if_valid", {31'h0, if_valid}, 32'h1);
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      tick();
      chk("pre-reset wait req", {31'h0, imem_req}, 32'h0);
      do_reset();
      chk("post-reset req", {31'h0, imem_req}, 32'h1);

      // Redirect to a non-word-aligned target.
      drive(0, 1, 32'h102, 0, 0, 32'h0);
      tick();
`ifdef IF_MISALIGN_CHECK_EN
      chk("mis addr", imem_addr, 32'h100);
      chk("mis pulse", {31'h0, misalign}, 32'h1);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      tick();
      chk("mis pulse end", {31'h0, misalign}, 32'h0);
`else
      chk("unaligned addr kept", imem_addr, 32'h102);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      model_init();
      for (int n = 0; n < 4000; n++) step_rand();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_ctrl.md
IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded on reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard unit: hold IF/ID outputs and the PC.
REQ-005 redirect  input  1  EXE-stage taken branch/jump.
REQ-006 redirect_pc  input  32  EXE-stage target address.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  32  fetch address; equals the PC register.
REQ-009 imem_ready  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  fetch response valid.
REQ-011 imem_rdata  input  32  fetched instruction.
REQ-012 if_valid  output  1  IF/ID entry valid.
REQ-013 if_pc  output  32  PC of the IF/ID instruction.
REQ-014 if_instr  output  32  IF/ID instruction.
REQ-015 misalign  output  1  misaligned-target pulse; present only under the macro in REQ-031.

Function
REQ-016 States: REQ (drive request), WAIT (one request outstanding), HOLD (response buffered during stall), DROP (discard stale response).
REQ-017 REQ: imem_req=1; imem_req&&imem_ready -> WAIT; at most one outstanding request at any time.
REQ-018 WAIT, imem_rvalid, stall=0: IF/ID <= {1, pc, imem_rdata} at the next edge; pc <= pc+4; -> REQ.
REQ-019 WAIT, imem_rvalid, stall=1: response stored in a one-entry buffer; IF/ID unchanged; -> HOLD.
REQ-020 HOLD: imem_req=0; when stall falls, the buffer loads IF/ID; pc <= pc+4; -> REQ; fetch-to-IF/ID latency is therefore 1 cycle after stall release.
REQ-021 Cycles with stall=0 and no IF/ID load SHALL set if_valid=0 (bubble); stall=1 holds if_valid/if_pc/if_instr.
REQ-022 Redirect has highest priority, including over stall: pc <= redirect_pc; if_valid <= 0; buffer cleared.
REQ-023 Redirect with a request outstanding (WAIT, or REQ handshake in the same cycle) -> DROP; otherwise -> REQ.
REQ-024 Redirect coinciding with imem_rvalid in WAIT: response discarded, -> REQ (nothing outstanding).
REQ-025 DROP: imem_req=0; next imem_rvalid discarded, -> REQ; a further redirect in DROP updates pc and stays in DROP.
REQ-026 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 imem_rvalid outside WAIT/DROP is ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force pc=RESET_PC, state=REQ, if_valid=0, if_pc=0, if_instr=0, buffer empty, misalign=0.
REQ-029 Reset during WAIT/DROP abandons the outstanding request; the memory is reset by the same rst_n.
REQ-030 First imem_req SHALL be asserted in the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro IF_MISALIGN_CHECK_EN: when defined, a redirect with redirect_pc[1:0]!=0 loads pc={redirect_pc[31:2],2'b00} and pulses misalign for exactly 1 cycle (registered).
REQ-032 Without IF_MISALIGN_CHECK_EN: misalign port absent; redirect_pc loaded unmodified.

Structure
REQ-033 Shared package if_pkg: state enumeration, RESET_PC default, INSTR_NOP=32'h0000_0013.
REQ-034 One sub-module, if_next_pc_sel: combinational select of redirect_pc vs pc+4 driven by the controller.

Verification
REQ-035 Reset, imem_ready=1, rvalid one cycle after accept -> imem_addr 0,4,8; if_pc 0,4,8 with if_valid=1 on consecutive responses.
REQ-036 stall=1 when rvalid arrives for pc=8 -> IF/ID holds pc=4; state HOLD; stall=0 -> if_pc=8 next cycle; next imem_addr=12.
REQ-037 redirect=1, redirect_pc=32'h100 while in WAIT -> stale response dropped; if_valid=0; next imem_addr=32'h100; first if_pc=32'h100.
REQ-038 redirect and rvalid in the same cycle, stall=1 -> response discarded; imem_addr=redirect_pc next cycle; if_valid=0.
REQ-039 pc=32'hFFFF_FFFC fetched -> next imem_addr=32'h0000_0000.
REQ-040 With IF_MISALIGN_CHECK_EN, redirect_pc=32'h102 -> imem_addr=32'h100; misalign high exactly 1 cycle.
